// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [31:0] INSTR_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc_next;
    logic [31:0] instr;
  } fifo_entry_t;

  function automatic logic [31:0] step_pc(input logic [31:0] pc);
    return pc + INSTR_STEP;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory request/ack bus
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc_next, instr} entries with synchronous flush
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fifo_entry_t              push_data,
  input  logic                     pop,
  output fifo_entry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  fifo_entry_t     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch stage: PC, imem handshake, prefetch FIFO, IF/ID register
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_addr,
  if_fetch_unit_if.master         imem,
  output logic [31:0]             PC,
  output logic [31:0]             Instruction,
  output logic                    valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  fifo_entry_t   fifo_head;
  fifo_entry_t   fetch_entry;

  logic take;
  logic fifo_pop;
  logic req;
  logic accepted;
  logic keep_word;
  logic bypass;
  logic want_push;
  logic fifo_push;
  logic outstanding;

  assign take     = !branch_taken && !freeze;
  assign fifo_pop = take && !fifo_empty;
  assign req      = rst && (state != DROP) && ((fifo_count < DEPTH_C) || fifo_pop);

  assign accepted  = imem.imem_ack && ((state == WAIT) || (state == IDLE && req));
  assign keep_word = accepted && !branch_taken;
  // An empty FIFO with decode ready forwards the word straight into IF/ID.
  assign bypass    = keep_word && take && fifo_empty;
  assign want_push = keep_word && !bypass;
  assign fifo_push = want_push && (!fifo_full || fifo_pop);

  assign fetch_entry = '{pc_next: step_pc(fetch_pc), instr: imem.imem_rdata};

  assign outstanding = (state == IDLE) ? (req && !imem.imem_ack) : !imem.imem_ack;

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (fifo_push),
    .push_data (fetch_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      PC          <= 32'h0;
      Instruction <= BUBBLE_INSTR;
      valid       <= 1'b0;
    end else begin
      // A redirect with the old request still in flight must swallow its data.
      if (!outstanding)                       state <= IDLE;
      else if (branch_taken || state == DROP) state <= DROP;
      else                                    state <= WAIT;

      if (branch_taken)  fetch_pc <= branch_addr;
      else if (accepted) fetch_pc <= step_pc(fetch_pc);

      if (branch_taken) begin
        Instruction <= BUBBLE_INSTR;
        valid       <= 1'b0;
      end else if (!freeze) begin
        if (fifo_pop) begin
          PC          <= fifo_head.pc_next;
          Instruction <= fifo_head.instr;
          valid       <= 1'b1;
        end else if (bypass) begin
          PC          <= fetch_entry.pc_next;
          Instruction <= fetch_entry.instr;
          valid       <= 1'b1;
        end else begin
          Instruction <= BUBBLE_INSTR;
          valid       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;

  int nvec = 0;
  int nerr = 0;
  int waits = 0;

  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr_l;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (bus),
    .PC           (pc_o),
    .Instruction  (instr_o),
    .valid        (valid_o)
  );

  always #5 clk = ~clk;

  // Memory returns the request address as the instruction word.
  always_comb begin
    if (mem_busy) begin
      bus.imem_ack   = (mem_cnt == 0);
      bus.imem_rdata = mem_addr_l;
    end else begin
      bus.imem_ack   = bus.imem_req && (waits == 0);
      bus.imem_rdata = bus.imem_addr;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_busy   <= 1'b0;
      mem_cnt    <= 0;
      mem_addr_l <= 32'h0;
    end else if (mem_busy) begin
      if (mem_cnt == 0) mem_busy <= 1'b0;
      else              mem_cnt  <= mem_cnt - 1;
    end else if (bus.imem_req && waits != 0) begin
      mem_busy   <= 1'b1;
      mem_cnt    <= waits - 1;
      mem_addr_l <= bus.imem_addr;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (mem_busy && bus.imem_req) begin
        nvec++;
        if (bus.imem_addr !== mem_addr_l) begin
          nerr++;
          $display("FAIL addr_stable got %h want %h", bus.imem_addr, mem_addr_l);
        end
      end
      nvec++;
      if (dut.want_push && dut.fifo_full && !dut.fifo_pop) begin
        nerr++;
        $display("FAIL push_full got push into full FIFO want none");
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int w);
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; waits = w;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; waits = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    nvec++;
    if (bus.imem_req !== 1'b0) begin
      nerr++; $display("FAIL rst_req got %b want 0", bus.imem_req);
    end
    nvec++;
    if ({valid_o, pc_o, instr_o} !== 65'h0) begin
      nerr++; $display("FAIL rst_out got v=%b pc=%h i=%h want 0/0/0", valid_o, pc_o, instr_o);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if (!(bus.imem_req === 1'b1 && bus.imem_addr === 32'h0)) begin
      nerr++; $display("FAIL rst_first_req got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_zero_wait;
    do_reset(0);
    @(negedge clk);
    nvec++;
    if (!(bus.imem_req === 1'b1 && bus.imem_addr === 32'h0)) begin
      nerr++; $display("FAIL zw_req got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr);
    end
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      @(negedge clk);
      nvec++;
      if ({valid_o, pc_o, instr_o} !== {1'b1, 32'(4*k), 32'(4*(k-1))}) begin
        nerr++;
        $display("FAIL zw_out%0d got v=%b pc=%h i=%h want 1/%h/%h", k, valid_o, pc_o, instr_o, 32'(4*k), 32'(4*(k-1)));
      end
    end
  endtask

  task automatic test_wait_states;
    do_reset(2);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) next_cycle();
      @(negedge clk);
      nvec++;
      if (!(bus.imem_req === 1'b1 && bus.imem_addr === 32'h0)) begin
        nerr++; $display("FAIL ws_hold%0d got req=%b addr=%h want 1/0", c, bus.imem_req, bus.imem_addr);
      end
    end
    for (int c = 4; c <= 15; c++) begin
      logic [31:0] ei;
      next_cycle();
      @(negedge clk);
      ei = 32'(4 * ((c - 4) / 3));
      nvec++;
      if ((c - 4) % 3 == 0) begin
        if ({valid_o, pc_o, instr_o} !== {1'b1, ei + 32'd4, ei}) begin
          nerr++; $display("FAIL ws_c%0d got v=%b pc=%h i=%h want 1/%h/%h", c, valid_o, pc_o, instr_o, ei + 32'd4, ei);
        end
      end else if (!(valid_o === 1'b0 && instr_o === 32'h0)) begin
        nerr++; $display("FAIL ws_bubble_c%0d got v=%b i=%h want 0/0", c, valid_o, instr_o);
      end
    end
  endtask

  task automatic test_freeze;
    do_reset(0);
    next_cycle();
    next_cycle();
    next_cycle();
    freeze = 1'b1;
    for (int c = 4; c <= 7; c++) begin
      if (c > 4) next_cycle();
      @(negedge clk);
      nvec++;
      if ({valid_o, pc_o, instr_o} !== {1'b1, 32'd12, 32'd8}) begin
        nerr++; $display("FAIL frz_hold_c%0d got v=%b pc=%h i=%h want 1/c/8", c, valid_o, pc_o, instr_o);
      end
      if (c >= 6) begin
        nvec++;
        if (bus.imem_req !== 1'b0) begin
          nerr++; $display("FAIL frz_req_c%0d got %b want 0", c, bus.imem_req);
        end
      end
    end
    next_cycle();
    freeze = 1'b0;
    @(negedge clk);
    nvec++;
    if (pc_o !== 32'd12) begin
      nerr++; $display("FAIL frz_release got pc=%h want c", pc_o);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      nvec++;
      if ({valid_o, pc_o, instr_o} !== {1'b1, 32'(16 + 4*k), 32'(12 + 4*k)}) begin
        nerr++; $display("FAIL frz_drain%0d got v=%b pc=%h i=%h want 1/%h/%h", k, valid_o, pc_o, instr_o, 32'(16 + 4*k), 32'(12 + 4*k));
      end
    end
  endtask

  task automatic test_branch;
    logic        seen_req, seen_val;
    logic [31:0] first_addr, first_pc, first_instr;
    seen_req = 1'b0; seen_val = 1'b0;
    first_addr = 32'h0; first_pc = 32'h0; first_instr = 32'h0;
    do_reset(3);
    for (int c = 1; c <= 16; c++) next_cycle();
    @(negedge clk);
    nvec++;
    if (!(bus.imem_req === 1'b1 && bus.imem_addr === 32'h10)) begin
      nerr++; $display("FAIL br_pre got req=%b addr=%h want 1/10", bus.imem_req, bus.imem_addr);
    end
    next_cycle();
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    next_cycle();
    branch_taken = 1'b0;
    @(negedge clk);
    nvec++;
    if (!(valid_o === 1'b0 && instr_o === 32'h0 && bus.imem_req === 1'b0)) begin
      nerr++; $display("FAIL br_drop got v=%b i=%h req=%b want 0/0/0", valid_o, instr_o, bus.imem_req);
    end
    for (int i = 0; i < 40 && !(seen_req && seen_val); i++) begin
      if (i > 0) begin
        next_cycle();
        @(negedge clk);
      end
      if (!seen_req && bus.imem_req) begin
        seen_req = 1'b1; first_addr = bus.imem_addr;
      end
      if (!seen_val && valid_o) begin
        seen_val = 1'b1; first_pc = pc_o; first_instr = instr_o;
      end
    end
    nvec++;
    if (!(seen_req && first_addr === 32'h100)) begin
      nerr++; $display("FAIL br_req got seen=%b addr=%h want 1/100", seen_req, first_addr);
    end
    nvec++;
    if (!(seen_val && first_pc === 32'h104 && first_instr === 32'h100)) begin
      nerr++; $display("FAIL br_out got seen=%b pc=%h i=%h want 1/104/100", seen_val, first_pc, first_instr);
    end
  endtask

  task automatic test_branch_freeze;
    do_reset(0);
    next_cycle();
    next_cycle();
    next_cycle();
    freeze       = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    next_cycle();
    branch_taken = 1'b0;
    @(negedge clk);
    nvec++;
    if (!(valid_o === 1'b0 && instr_o === 32'h0)) begin
      nerr++; $display("FAIL bf_flush got v=%b i=%h want 0/0", valid_o, instr_o);
    end
    nvec++;
    if (!(bus.imem_req === 1'b1 && bus.imem_addr === 32'h200)) begin
      nerr++; $display("FAIL bf_req got req=%b addr=%h want 1/200", bus.imem_req, bus.imem_addr);
    end
    next_cycle();
    @(negedge clk);
    nvec++;
    if (valid_o !== 1'b0) begin
      nerr++; $display("FAIL bf_hold got v=%b want 0", valid_o);
    end
    next_cycle();
    freeze = 1'b0;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge clk);
      nvec++;
      if ({valid_o, pc_o, instr_o} !== {1'b1, 32'(32'h204 + 4*k), 32'(32'h200 + 4*k)}) begin
        nerr++; $display("FAIL bf_out%0d got v=%b pc=%h i=%h want 1/%h/%h", k, valid_o, pc_o, instr_o, 32'(32'h204 + 4*k), 32'(32'h200 + 4*k));
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_pc [3];
    logic [31:0] exp_i [3];
    exp_pc[0] = 32'hFFFF_FFFC; exp_i[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'h0000_0000; exp_i[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0004; exp_i[2] = 32'h0000_0000;
    do_reset(0);
    next_cycle();
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFF8;
    next_cycle();
    branch_taken = 1'b0;
    @(negedge clk);
    nvec++;
    if (!(valid_o === 1'b0 && bus.imem_addr === 32'hFFFF_FFF8)) begin
      nerr++; $display("FAIL wrap_redirect got v=%b addr=%h want 0/fffffff8", valid_o, bus.imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      nvec++;
      if ({valid_o, pc_o, instr_o} !== {1'b1, exp_pc[k], exp_i[k]}) begin
        nerr++; $display("FAIL wrap_out%0d got v=%b pc=%h i=%h want 1/%h/%h", k, valid_o, pc_o, instr_o, exp_pc[k], exp_i[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(2);
    for (int c = 1; c <= 4; c++) next_cycle();
    @(negedge clk);
    nvec++;
    if (!(bus.imem_req === 1'b1 && bus.imem_addr === 32'h4)) begin
      nerr++; $display("FAIL rm_wait got req=%b addr=%h want 1/4", bus.imem_req, bus.imem_addr);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if ({bus.imem_req, valid_o, pc_o, instr_o} !== 66'h0) begin
      nerr++; $display("FAIL rm_async got req=%b v=%b pc=%h i=%h want all 0", bus.imem_req, valid_o, pc_o, instr_o);
    end
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if (!(bus.imem_req === 1'b1 && bus.imem_addr === 32'h0)) begin
      nerr++; $display("FAIL rm_restart got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr);
    end
    for (int c = 2; c <= 4; c++) next_cycle();
    @(negedge clk);
    nvec++;
    if ({valid_o, pc_o, instr_o} !== {1'b1, 32'd4, 32'd0}) begin
      nerr++; $display("FAIL rm_first got v=%b pc=%h i=%h want 1/4/0", valid_o, pc_o, instr_o);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_freeze();
    test_branch();
    test_branch_freeze();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that feeds the decode stage.
- Owns the PC and issues requests to instruction memory through a req/ack handshake.
- Buffers fetched words in a small prefetch FIFO and presents {PC+4, Instruction, valid} to decode through a registered IF/ID boundary.
- Honours decode's hazard freeze and the execute stage's taken-branch redirect.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, at least 2).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hazard from decode; holds the IF/ID outputs.
- branch_taken  in  1  one-cycle redirect pulse from execute.
- branch_addr  in  32  redirect target, sampled when branch_taken=1.
- imem_req  out  1  memory request.
- imem_addr  out  32  request address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  data-valid strobe; may assert in the same cycle as imem_req (zero-wait).
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- PC  out  32  address of the delivered instruction + 4.
- Instruction  out  32  delivered instruction word.
- valid  out  1  1 when PC/Instruction hold a real instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; state=IDLE.
  - imem_req=0; PC=0, Instruction=0, valid=0.
  - The first request is issued in the first cycle after rst deasserts.
- Memory handshake:
  - At most one request outstanding.
  - Once imem_req=1, imem_req and imem_addr stay constant until the cycle in which imem_ack=1; data is taken in that cycle.
  - On an accepted word, fetch_pc += 4.
- Issue rule: imem_req=1 when state≠DROP and (FIFO count < FIFO_DEPTH, or a FIFO pop occurs this cycle).
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DROP: request outstanding whose data must be discarded.
- FSM transitions:
  - IDLE→WAIT when a request is issued and not acked in the same cycle.
  - WAIT→IDLE on ack, or stay in WAIT if a new request issues in the ack cycle with no ack.
  - DROP→IDLE on ack. The data is discarded and imem_req is 0 in that cycle; the first request to the new fetch_pc issues in the next cycle.
- FIFO entry: {fetch_pc+4, imem_rdata}. Push on an accepted ack when state≠DROP and no redirect this cycle.
- IF/ID register, when freeze=0 and branch_taken=0:
  - FIFO non-empty: pop the head into PC/Instruction, valid=1.
  - FIFO empty: bubble (Instruction=0, valid=0, PC holds its previous value).
- IF/ID register, when freeze=1 and branch_taken=0: hold all outputs; no pop. Fetch keeps filling the FIFO until it is full.
- Redirect (branch_taken=1), which has priority over freeze:
  - fetch_pc ← branch_addr; FIFO flushed.
  - Outputs become a bubble (valid=0, Instruction=0).
  - If a request is outstanding and not acked this cycle, state→DROP; otherwise state→IDLE.
  - A same-cycle ack is discarded.
  - The request to branch_addr issues in the next cycle at the earliest.
- Branch while in DROP: update fetch_pc to the new target and remain in DROP.
- Simultaneous push and pop: allowed; the count is unchanged.
- Push into a full FIFO: cannot occur because of the issue rule. The bench asserts this.
- Address arithmetic: fetch_pc and PC are modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Latency with zero-wait memory: an instruction fetched in cycle n appears at the outputs in cycle n+1 at the earliest. Steady-state throughput is 1 instruction per cycle.

Decomposition:
- Package if_pkg holds:
  - the fetch FSM enum (IDLE/WAIT/DROP);
  - BUBBLE_INSTR=32'h0;
  - the instruction step constant 4;
  - the FIFO entry struct {pc_next[31:0], instr[31:0]}.
- One sub-module, fetch_fifo: parameterised depth, synchronous flush, push/pop, full/empty/count, same active-low asynchronous reset.

Test Plan:
- Reset, then zero-wait memory returning the address as data: imem_addr=0 in cycle 1; from cycle 2 outputs valid=1, PC=4, Instruction=0, then PC=8 (Instruction=4), PC=12 (Instruction=8), one per cycle.
- Memory with 2 wait states: imem_addr held at 0 for 3 cycles. Each instruction delivered once; bubbles (valid=0) between instructions; no duplicates.
- freeze=1 for 4 cycles mid-stream: outputs hold PC=12. FIFO fills to 2 and imem_req drops. After release, Instruction=12, 16, 20 arrive back-to-back with no gap and no loss.
- branch_taken with branch_addr=0x100 while a 3-wait request to 0x10 is outstanding: that data is discarded. The next imem_addr is 0x100; the first valid output is PC=0x104, and nothing from 0x10 is delivered.
- branch_taken together with freeze=1: valid=0 next cycle (flush wins). The first instruction after release comes from the target address.
- rst asserted while in WAIT mid-stream: all outputs zero immediately and imem_req=0. After release, fetch restarts at RESET_PC.
